// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: states,
// 6-bit opcodes, ALUOp, PCSrc and RegDst codes, plus the opcode class bundle.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_WB   = 3'b011,
    S_MEM  = 3'b100,
    S_HALT = 3'b101,
    S_ERR  = 3'b110
  } state_t;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLTIU = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;

  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JR   = 2'b10;
  localparam logic [1:0] PC_JMP  = 2'b11;

  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  // wb_ok: opcode is defined and writes the register file in WB
  typedef struct packed {
    logic jump;
    logic jal;
    logic halt;
    logic branch;
    logic lw;
    logic sw;
    logic wb_ok;
  } op_cls_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: datapath mux selects, PCSrc, ALUOp and the
// opcode class used by the FSM. Opcodes with nonzero upper bits are undefined.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               sign,
  output logic               alu_src_a,
  output logic               alu_src_b,
  output logic               db_data_src,
  output logic               wr_reg_d_src,
  output logic               ext_sel,
  output logic [1:0]         reg_dst,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output op_cls_t            cls
);

  logic [5:0] op6;
  logic       hi_zero;
  logic [2:0] aluop3;

  assign op6 = op[5:0];

  generate
    if (OP_W > 6) begin : g_hi
      assign hi_zero = (op[OP_W-1:6] == '0);
    end else begin : g_nohi
      assign hi_zero = 1'b1;
    end
  endgenerate

  always_comb begin
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    db_data_src  = 1'b0;
    wr_reg_d_src = 1'b1;
    ext_sel      = 1'b1;
    reg_dst      = RD_RD;
    pc_src       = PC_NEXT;
    aluop3       = ALU_ADD;
    cls          = '0;
    if (hi_zero) begin
      case (op6)
        OP_ADD:   cls.wb_ok = 1'b1;
        OP_SUB:   begin aluop3 = ALU_SUB; cls.wb_ok = 1'b1; end
        OP_ADDI:  begin alu_src_b = 1'b1; reg_dst = RD_RT; cls.wb_ok = 1'b1; end
        OP_OR:    begin aluop3 = ALU_OR;  cls.wb_ok = 1'b1; end
        OP_AND:   begin aluop3 = ALU_AND; cls.wb_ok = 1'b1; end
        OP_ORI: begin
          alu_src_b = 1'b1; ext_sel = 1'b0; reg_dst = RD_RT;
          aluop3 = ALU_OR; cls.wb_ok = 1'b1;
        end
        OP_SLL:   begin alu_src_a = 1'b1; aluop3 = ALU_SLL; cls.wb_ok = 1'b1; end
        OP_SLT:   begin aluop3 = ALU_SLT; cls.wb_ok = 1'b1; end
        OP_SLTIU: begin
          alu_src_b = 1'b1; ext_sel = 1'b0; reg_dst = RD_RT;
          aluop3 = ALU_SLTU; cls.wb_ok = 1'b1;
        end
        OP_SW:    begin alu_src_b = 1'b1; cls.sw = 1'b1; end
        OP_LW: begin
          alu_src_b = 1'b1; db_data_src = 1'b1; reg_dst = RD_RT;
          cls.lw = 1'b1; cls.wb_ok = 1'b1;
        end
        OP_BEQ: begin
          aluop3 = ALU_SUB; cls.branch = 1'b1;
          pc_src = zero ? PC_BR : PC_NEXT;
        end
        OP_BLTZ: begin
          aluop3 = ALU_SLT; cls.branch = 1'b1;
          pc_src = (sign && !zero) ? PC_BR : PC_NEXT;
        end
        OP_J:     begin pc_src = PC_JMP; cls.jump = 1'b1; end
        OP_JR:    begin pc_src = PC_JR;  cls.jump = 1'b1; end
        OP_JAL: begin
          pc_src = PC_JMP; wr_reg_d_src = 1'b0; reg_dst = RD_RA;
          cls.jump = 1'b1; cls.jal = 1'b1;
        end
        OP_HALT:  cls.halt = 1'b1;
        default:  ;
      endcase
    end
  end

  assign alu_op = ALUOP_W'(aluop3);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control FSM with req/ack memory handshake, wait timeout and
// sticky bus error. Optional perf counters under `CTRL_PERF_CNT_EN`.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int TMO_W   = 4,
  parameter int MEM_TMO = 12
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               sign,
  input  logic               imem_ack,
  input  logic               dmem_ack,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               PCWre,
  output logic               IRWre,
  output logic               RegWre,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               DBDataSrc,
  output logic               WrRegDSrc,
  output logic               nRD,
  output logic               nWR,
  output logic               ExtSel,
  output logic [1:0]         PCSrc,
  output logic [1:0]         RegDst,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [2:0]         state,
  output logic               halted,
  output logic               bus_err
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]        instr_cnt,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        cyc_cnt
`endif
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TMO - 1);

  state_t             cur, nxt;
  logic [TMO_W-1:0]   wcnt, wcnt_nxt;
  logic               waiting, tmo;
  op_cls_t            cls;
  logic               d_src_a, d_src_b, d_db, d_wr, d_ext;
  logic [1:0]         d_rd, d_pcs;
  logic [ALUOP_W-1:0] d_alu;

  ctrl_decode #(.OP_W(OP_W), .ALUOP_W(ALUOP_W)) u_dec (
    .op           (op),
    .zero         (zero),
    .sign         (sign),
    .alu_src_a    (d_src_a),
    .alu_src_b    (d_src_b),
    .db_data_src  (d_db),
    .wr_reg_d_src (d_wr),
    .ext_sel      (d_ext),
    .reg_dst      (d_rd),
    .pc_src       (d_pcs),
    .alu_op       (d_alu),
    .cls          (cls)
  );

  // Counter is nonzero only while a req is outstanding, so it is zero on
  // entry to IF/MEM. The last allowed wait cycle without ack is the timeout.
  assign waiting  = (cur == S_IF && !imem_ack) || (cur == S_MEM && !dmem_ack);
  assign tmo      = waiting && (wcnt == TMO_LAST);
  assign wcnt_nxt = (waiting && !tmo) ? wcnt + TMO_W'(1) : '0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cur  <= S_IF;
      wcnt <= '0;
    end else begin
      cur  <= nxt;
      wcnt <= wcnt_nxt;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IF:   if (imem_ack) nxt = S_ID; else if (tmo) nxt = S_ERR;
      S_ID:   if (cls.jump) nxt = S_IF; else if (cls.halt) nxt = S_HALT; else nxt = S_EXE;
      S_EXE:  if (cls.branch) nxt = S_IF; else if (cls.lw || cls.sw) nxt = S_MEM; else nxt = S_WB;
      S_MEM:  if (dmem_ack) nxt = cls.sw ? S_IF : S_WB; else if (tmo) nxt = S_ERR;
      S_WB:   nxt = S_IF;
      S_HALT, S_ERR: nxt = cur;
      default: nxt = S_ERR;
    endcase
  end

  // RST gates every output combinationally so a reset mid-access drops
  // the strobes immediately rather than at the next edge.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    nRD       = 1'b0;
    nWR       = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    DBDataSrc = 1'b0;
    WrRegDSrc = 1'b1;
    ExtSel    = 1'b1;
    PCSrc     = PC_NEXT;
    RegDst    = RD_RD;
    ALUOp     = '0;
    halted    = 1'b0;
    bus_err   = 1'b0;
    if (RST) begin
      ALUSrcA   = d_src_a;
      ALUSrcB   = d_src_b;
      DBDataSrc = d_db;
      WrRegDSrc = d_wr;
      ExtSel    = d_ext;
      PCSrc     = d_pcs;
      RegDst    = d_rd;
      ALUOp     = d_alu;
      halted    = (cur == S_HALT);
      bus_err   = (cur == S_ERR);
      case (cur)
        S_IF: begin
          imem_req = 1'b1;
          IRWre    = imem_ack;
        end
        S_ID: if (cls.jump) begin
          PCWre  = 1'b1;
          RegWre = cls.jal;
        end
        S_EXE: PCWre = cls.branch;
        S_MEM: begin
          dmem_req = 1'b1;
          nRD      = cls.lw;
          nWR      = cls.sw;
          PCWre    = dmem_ack && cls.sw;
        end
        S_WB: begin
          PCWre  = 1'b1;
          RegWre = cls.wb_ok;
        end
        default: ;
      endcase
    end
  end

  assign state = cur;

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      instr_cnt <= '0;
      stall_cnt <= '0;
      cyc_cnt   <= '0;
    end else begin
      if (PCWre)                          instr_cnt <= instr_cnt + 32'd1;
      if (waiting)                        stall_cnt <= stall_cnt + 32'd1;
      if (cur != S_HALT && cur != S_ERR)  cyc_cnt   <= cyc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: expected control vectors are
// queued as each cycle's stimulus is applied and popped at the falling edge.
`timescale 1ns/1ps
module tb_multicycle_ctrl_fsm;
  import ctrl_pkg::*;

  logic       CLK = 1'b0, RST = 1'b0;
  logic [5:0] op = OP_ADD;
  logic       zero = 1'b0, sign = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic       imem_req, dmem_req, PCWre, IRWre, RegWre, ALUSrcA, ALUSrcB;
  logic       DBDataSrc, WrRegDSrc, nRD, nWR, ExtSel, halted, bus_err;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp, state;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instr_cnt, stall_cnt, cyc_cnt;
`endif

  int total = 0, bad = 0;
  logic [11:0] exp_q[$];
  logic [11:0] obs, dobs;

  always #5 CLK = ~CLK;

  multicycle_ctrl_fsm #(.OP_W(6), .ALUOP_W(3), .TMO_W(4), .MEM_TMO(12)) dut (
    .CLK(CLK), .RST(RST), .op(op), .zero(zero), .sign(sign),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .PCWre(PCWre), .IRWre(IRWre),
    .RegWre(RegWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc),
    .WrRegDSrc(WrRegDSrc), .nRD(nRD), .nWR(nWR), .ExtSel(ExtSel),
    .PCSrc(PCSrc), .RegDst(RegDst), .ALUOp(ALUOp), .state(state),
    .halted(halted), .bus_err(bus_err)
`ifdef CTRL_PERF_CNT_EN
    , .instr_cnt(instr_cnt), .stall_cnt(stall_cnt), .cyc_cnt(cyc_cnt)
`endif
  );

  assign obs  = {state, imem_req, dmem_req, PCWre, IRWre, RegWre, nRD, nWR, halted, bus_err};
  assign dobs = {ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel, RegDst, PCSrc, ALUOp};

  function automatic logic [11:0] cv(logic [2:0] st, logic ireq, logic dreq, logic pc,
                                     logic ir, logic rw, logic rd, logic wr, logic h, logic be);
    return {st, ireq, dreq, pc, ir, rw, rd, wr, h, be};
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST = 1'b0; op = OP_ADD; zero = 1'b0; sign = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    RST = 1'b0; op = OP_JAL; zero = 1'b1; sign = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    exp_q.push_back(cv(S_IF, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(12'b0_0_0_1_1_10_00_000);
    @(negedge CLK);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL reset_ctrl got=%h want=%h", obs, e); end
    e = exp_q.pop_front(); total++;
    if (dobs !== e) begin bad++; $display("FAIL reset_decode got=%b want=%b", dobs, e); end
    @(posedge CLK); #1;
    RST = 1'b1; op = OP_ADD; zero = 1'b0; sign = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    exp_q.push_back(cv(S_IF, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge CLK);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL reset_first_if got=%h want=%h", obs, e); end
  endtask

  task automatic test_add();
    logic [11:0] e;
    logic [11:0] seq[5];
    seq = '{cv(S_IF, 1,0,0,1,0,0,0,0,0), cv(S_ID, 0,0,0,0,0,0,0,0,0), cv(S_EXE, 0,0,0,0,0,0,0,0,0),
            cv(S_WB, 0,0,1,0,1,0,0,0,0), cv(S_IF, 1,0,0,1,0,0,0,0,0)};
    do_reset(); op = OP_ADD; imem_ack = 1'b1;
    for (int c = 0; c < 5; c++) begin
      exp_q.push_back(seq[c]);
      @(negedge CLK);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL add c%0d got=%h want=%h", c, obs, e); end
      if (c == 3) begin
        total++;
        if ({ALUOp, RegDst} !== 5'b000_10) begin
          bad++; $display("FAIL add_wb_decode got=%b want=%b", {ALUOp, RegDst}, 5'b000_10);
        end
      end
`ifdef CTRL_PERF_CNT_EN
      if (c == 4) begin
        total++;
        if ({instr_cnt, stall_cnt, cyc_cnt} !== {32'd1, 32'd0, 32'd4}) begin
          bad++; $display("FAIL add_perf got=%0d/%0d/%0d want=1/0/4", instr_cnt, stall_cnt, cyc_cnt);
        end
      end
`endif
      tick();
    end
  endtask

  task automatic test_lw_stall();
    logic [11:0] e;
    do_reset(); op = OP_LW; imem_ack = 1'b1;
    for (int c = 0; c < 9; c++) begin
      dmem_ack = (c == 6);
      if (c == 0 || c == 8)  e = cv(S_IF, 1,0,0,1,0,0,0,0,0);
      else if (c == 1)       e = cv(S_ID, 0,0,0,0,0,0,0,0,0);
      else if (c == 2)       e = cv(S_EXE, 0,0,0,0,0,0,0,0,0);
      else if (c <= 6)       e = cv(S_MEM, 0,1,0,0,0,1,0,0,0);
      else                   e = cv(S_WB, 0,0,1,0,1,0,0,0,0);
      exp_q.push_back(e);
      @(negedge CLK);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL lw c%0d got=%h want=%h", c, obs, e); end
      if (c == 7) begin
        total++;
        if ({DBDataSrc, ALUSrcB} !== 2'b11) begin
          bad++; $display("FAIL lw_wb_src got=%b want=11", {DBDataSrc, ALUSrcB});
        end
      end
      tick();
    end
    dmem_ack = 1'b0;
  endtask

  task automatic test_branch();
    logic [11:0] e;
    logic [5:0] bop[5];
    logic [1:0] zs[5];
    logic [1:0] pcs[5];
    bop = '{OP_BEQ, OP_BEQ, OP_BLTZ, OP_BLTZ, OP_BLTZ};
    zs  = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b00};
    pcs = '{PC_BR, PC_NEXT, PC_BR, PC_NEXT, PC_NEXT};
    do_reset(); imem_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      op = bop[k]; {zero, sign} = zs[k];
      for (int c = 0; c < 3; c++) begin
        if (c == 0)      e = cv(S_IF, 1,0,0,1,0,0,0,0,0);
        else if (c == 1) e = cv(S_ID, 0,0,0,0,0,0,0,0,0);
        else             e = cv(S_EXE, 0,0,1,0,0,0,0,0,0);
        exp_q.push_back(e);
        @(negedge CLK);
        e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL branch%0d c%0d got=%h want=%h", k, c, obs, e); end
        if (c == 2) begin
          total++;
          if (PCSrc !== pcs[k]) begin bad++; $display("FAIL branch%0d_pcsrc got=%b want=%b", k, PCSrc, pcs[k]); end
        end
        tick();
      end
    end
    zero = 1'b0; sign = 1'b0;
  endtask

  task automatic test_timeout();
    logic [11:0] e;
    // fetch never acked: 12 IF wait cycles then ERR, stray acks ignored after
    do_reset();
    for (int c = 0; c < 15; c++) begin
      imem_ack = (c >= 12); dmem_ack = (c >= 12);
      e = (c < 12) ? cv(S_IF, 1,0,0,0,0,0,0,0,0) : cv(S_ERR, 0,0,0,0,0,0,0,0,1);
      exp_q.push_back(e);
      @(negedge CLK);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL tmo_if c%0d got=%h want=%h", c, obs, e); end
`ifdef CTRL_PERF_CNT_EN
      if (c == 14) begin
        total++;
        if ({instr_cnt, stall_cnt, cyc_cnt} !== {32'd0, 32'd12, 32'd12}) begin
          bad++; $display("FAIL tmo_perf got=%0d/%0d/%0d want=0/12/12", instr_cnt, stall_cnt, cyc_cnt);
        end
      end
`endif
      tick();
    end
    // ack on the last allowed cycle wins
    do_reset();
    for (int c = 0; c < 13; c++) begin
      imem_ack = (c == 11);
      if (c < 11)       e = cv(S_IF, 1,0,0,0,0,0,0,0,0);
      else if (c == 11) e = cv(S_IF, 1,0,0,1,0,0,0,0,0);
      else              e = cv(S_ID, 0,0,0,0,0,0,0,0,0);
      exp_q.push_back(e);
      @(negedge CLK);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL tmo_ack_edge c%0d got=%h want=%h", c, obs, e); end
      tick();
    end
    // data access never acked
    do_reset(); op = OP_SW;
    for (int c = 0; c < 17; c++) begin
      imem_ack = (c == 0); dmem_ack = 1'b0;
      if (c == 0)       e = cv(S_IF, 1,0,0,1,0,0,0,0,0);
      else if (c == 1)  e = cv(S_ID, 0,0,0,0,0,0,0,0,0);
      else if (c == 2)  e = cv(S_EXE, 0,0,0,0,0,0,0,0,0);
      else if (c <= 14) e = cv(S_MEM, 0,1,0,0,0,0,1,0,0);
      else              e = cv(S_ERR, 0,0,0,0,0,0,0,0,1);
      exp_q.push_back(e);
      @(negedge CLK);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL tmo_mem c%0d got=%h want=%h", c, obs, e); end
      tick();
    end
  endtask

  task automatic test_jal_halt();
    logic [11:0] e;
    logic [5:0]  dops[18];
    logic [11:0] dx[18];
    dops = '{OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT, OP_SLTIU,
             OP_SW, OP_LW, OP_BEQ, OP_BLTZ, OP_J, OP_JR, OP_JAL, OP_HALT, 6'b001111};
    dx = '{12'b0_0_0_1_1_10_00_000, 12'b0_0_0_1_1_10_00_001, 12'b0_1_0_1_1_01_00_000,
           12'b0_0_0_1_1_10_00_011, 12'b0_0_0_1_1_10_00_100, 12'b0_1_0_1_0_01_00_011,
           12'b1_0_0_1_1_10_00_010, 12'b0_0_0_1_1_10_00_110, 12'b0_1_0_1_0_01_00_101,
           12'b0_1_0_1_1_10_00_000, 12'b0_1_1_1_1_01_00_000, 12'b0_0_0_1_1_10_00_001,
           12'b0_0_0_1_1_10_00_110, 12'b0_0_0_1_1_10_11_000, 12'b0_0_0_1_1_10_10_000,
           12'b0_0_0_0_1_00_11_000, 12'b0_0_0_1_1_10_00_000, 12'b0_0_0_1_1_10_00_000};
    do_reset(); op = OP_JAL; imem_ack = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (c == 2) op = OP_HALT;
      if (c == 0 || c == 2) e = cv(S_IF, 1,0,0,1,0,0,0,0,0);
      else if (c == 1)      e = cv(S_ID, 0,0,1,0,1,0,0,0,0);
      else if (c == 3)      e = cv(S_ID, 0,0,0,0,0,0,0,0,0);
      else                  e = cv(S_HALT, 0,0,0,0,0,0,0,1,0);
      exp_q.push_back(e);
      @(negedge CLK);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL jal_halt c%0d got=%h want=%h", c, obs, e); end
      if (c == 1) begin
        total++;
        if ({PCSrc, RegDst, WrRegDSrc} !== 5'b11_00_0) begin
          bad++; $display("FAIL jal_id_decode got=%b want=11000", {PCSrc, RegDst, WrRegDSrc});
        end
      end
      tick();
    end
    // decode table swept while parked in HALT
    for (int k = 0; k < 18; k++) begin
      op = dops[k];
      exp_q.push_back(dx[k]);
      @(negedge CLK);
      e = exp_q.pop_front(); total++;
      if (dobs !== e) begin bad++; $display("FAIL decode op=%b got=%b want=%b", dops[k], dobs, e); end
      total++;
      if (obs !== cv(S_HALT, 0,0,0,0,0,0,0,1,0)) begin bad++; $display("FAIL halt_hold k%0d got=%h", k, obs); end
      tick();
    end
  endtask

  task automatic test_undef();
    logic [11:0] e;
    logic [11:0] seq[5];
    seq = '{cv(S_IF, 1,0,0,1,0,0,0,0,0), cv(S_ID, 0,0,0,0,0,0,0,0,0), cv(S_EXE, 0,0,0,0,0,0,0,0,0),
            cv(S_WB, 0,0,1,0,0,0,0,0,0), cv(S_IF, 1,0,0,1,0,0,0,0,0)};
    do_reset(); op = 6'b001111; imem_ack = 1'b1;
    for (int c = 0; c < 5; c++) begin
      exp_q.push_back(seq[c]);
      @(negedge CLK);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL undef c%0d got=%h want=%h", c, obs, e); end
      tick();
    end
  endtask

  task automatic test_rst_mid_mem();
    logic [11:0] e;
    do_reset(); op = OP_SW;
    for (int c = 0; c < 5; c++) begin
      imem_ack = (c == 0);
      if (c == 0)      e = cv(S_IF, 1,0,0,1,0,0,0,0,0);
      else if (c == 1) e = cv(S_ID, 0,0,0,0,0,0,0,0,0);
      else if (c == 2) e = cv(S_EXE, 0,0,0,0,0,0,0,0,0);
      else             e = cv(S_MEM, 0,1,0,0,0,0,1,0,0);
      exp_q.push_back(e);
      @(negedge CLK);
      e = exp_q.pop_front(); total++;
      if (obs !== e) begin bad++; $display("FAIL rst_mem c%0d got=%h want=%h", c, obs, e); end
      if (c < 4) tick();
    end
    #2 RST = 1'b0;
    exp_q.push_back(cv(S_IF, 0,0,0,0,0,0,0,0,0));
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL rst_async_drop got=%h want=%h", obs, e); end
    @(posedge CLK); #1;
    RST = 1'b1; imem_ack = 1'b1;
    exp_q.push_back(cv(S_IF, 1,0,0,1,0,0,0,0,0));
    @(negedge CLK);
    e = exp_q.pop_front(); total++;
    if (obs !== e) begin bad++; $display("FAIL rst_release got=%h want=%h", obs, e); end
`ifdef CTRL_PERF_CNT_EN
    total++;
    if ({instr_cnt, stall_cnt, cyc_cnt} !== 96'd0) begin
      bad++; $display("FAIL rst_perf got=%0d/%0d/%0d want=0/0/0", instr_cnt, stall_cnt, cyc_cnt);
    end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_stall();
    test_branch();
    test_timeout();
    test_jal_halt();
    test_undef();
    test_rst_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Parametrised multi-cycle control unit for the MIPS-subset datapath. FSM phases are IF/ID/EXE/MEM/WB plus HALT and ERR.
- Adds a req/ack handshake to variable-latency instruction and data memories, with a bounded wait timeout.
- Adds a sticky bus-error state.
- Sits between the IR opcode field and all datapath enables (PC, IR, regfile, ALU muxes, memory).

Parameters:
OP_W, 6, opcode width; ISA opcodes are 6-bit constants zero-extended to OP_W; OP_W >= 6.
ALUOP_W, 3, ALUOp width; codes zero-extended; ALUOP_W >= 3.
TMO_W, 4, width of the memory-wait counter.
MEM_TMO, 12, max cycles a req may wait for ack; 1 <= MEM_TMO <= 2^TMO_W-1.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
op  in  OP_W  opcode from IR
zero  in  1  ALU zero flag
sign  in  1  ALU sign flag
imem_ack  in  1  instruction memory data valid
dmem_ack  in  1  data memory access complete
imem_req  out  1  fetch request
dmem_req  out  1  data access request
PCWre  out  1  PC write enable
IRWre  out  1  IR load enable
RegWre  out  1  register-file write enable
ALUSrcA  out  1  1 = shamt operand (sll)
ALUSrcB  out  1  1 = extended immediate
DBDataSrc  out  1  1 = memory data to writeback
WrRegDSrc  out  1  0 = PC+4 (jal)
nRD  out  1  data read strobe (lw)
nWR  out  1  data write strobe (sw)
ExtSel  out  1  0 = zero-extend (ori, sltiu)
PCSrc  out  2  00 PC+4, 01 branch, 10 jr, 11 j/jal
RegDst  out  2  00 $31, 01 rt, 10 rd
ALUOp  out  ALUOP_W  ALU function
state  out  3  current state, for debug
halted  out  1  high in HALT
bus_err  out  1  high in ERR (sticky)

Behaviour:
- State encoding: IF=000, ID=001, EXE=010, WB=011, MEM=100, HALT=101, ERR=110.
- Reset (RST low, async):
  - state=IF, wait counter=0.
  - All outputs 0 except WrRegDSrc=1, ExtSel=1, RegDst=10, IRWre=0.
  - On reset release, the first IF cycle raises imem_req.
- IF:
  - imem_req=1.
  - When imem_ack=1: IRWre=1 for that single cycle; go to ID.
  - Otherwise stay in IF and increment the counter.
- ID:
  - j/jal/jr: PCWre=1 and go to IF. jal also sets RegWre=1, RegDst=00, WrRegDSrc=0.
  - halt (111111): go to HALT with PCWre=0.
  - All other opcodes: go to EXE.
- EXE:
  - beq/bltz: PCWre=1, go to IF.
  - lw/sw: go to MEM.
  - Everything else: go to WB.
- MEM:
  - dmem_req=1; nRD=1 for lw, nWR=1 for sw.
  - Strobes are held constant until the dmem_ack cycle.
  - On ack: sw sets PCWre=1 and goes to IF; lw goes to WB.
- WB: RegWre=1, PCWre=1, go to IF.
- PCSrc is combinational from op, zero and sign:
  - beq: 01 iff zero=1.
  - bltz: 01 iff sign=1 and zero=0.
  - jr: 10. j/jal: 11. Otherwise 00.
- Datapath decodes are combinational from op only, as in the existing ISA map:
  - ALUSrcA = sll.
  - ALUSrcB = addi, ori, sltiu, sw, lw.
  - DBDataSrc = lw.
  - ExtSel = 0 for ori and sltiu.
  - RegDst = 01 for addi, ori, sltiu, lw; 00 for jal; 10 otherwise.
- ALUOp is combinational from op:
  - add/addi/sw/lw/j: 000. sub/beq: 001. sll: 010. or/ori: 011. and: 100. sltiu: 101. slt/bltz: 110.
  - Undefined opcode: 000.
- Undefined opcode: treated as a NOP through EXE→WB with RegWre forced 0; PCWre=1 in WB.
- Wait counter:
  - Cleared on entry to IF and to MEM, and whenever ack is seen.
  - If the counter reaches MEM_TMO with ack still 0: go to ERR. No PCWre, RegWre or IRWre in that cycle.
  - An ack arriving in the same cycle as the timeout wins, and normal progress continues.
- ERR: bus_err=1, all enables and reqs 0. Leaves only via RST.
- HALT: halted=1, all enables and reqs 0. Leaves only via RST.
- Stray acks outside a req cycle are ignored.
- RST asserted mid-MEM drops dmem_req, nRD and nWR immediately (async).
- Write enables (PCWre, RegWre, IRWre) are combinational within the state. They are never asserted for more than one cycle per instruction phase.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- When defined, adds three outputs:
  - instr_cnt[31:0]: increments on each PCWre=1 cycle.
  - stall_cnt[31:0]: increments on each cycle in IF or MEM with req=1 and ack=0.
  - cyc_cnt[31:0]: increments every cycle not in HALT/ERR.
- All three counters reset to 0 on RST and wrap modulo 2^32.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package ctrl_pkg holds:
  - state encodings;
  - 6-bit opcode constants (add … halt);
  - ALUOp codes;
  - PCSrc and RegDst codes.
- One sub-module, ctrl_decode: purely combinational op/zero/sign → ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel, RegDst, PCSrc, ALUOp.
- The FSM, wait counter and perf counters stay in the top.

Test Plan:
- add with imem_ack tied 1 → states IF,ID,EXE,WB,IF. RegWre=1 and PCWre=1 only in WB; ALUOp=000, RegDst=10.
- lw with dmem_ack delayed 3 cycles → MEM held 4 cycles with nRD=1 and dmem_req=1 throughout; then WB with DBDataSrc=1 and RegWre=1.
- beq with zero=1 → PCSrc=01 and PCWre=1 in EXE. Repeat with zero=0 → PCSrc=00. bltz with sign=1, zero=0 → PCSrc=01.
- imem_ack never asserted, MEM_TMO=12 → ERR entered after 12 wait cycles with bus_err=1 and no PCWre. Ack arriving exactly on cycle 12 → ID entered instead.
- jal → ID cycle shows PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0, then IF. halt → HALT with halted=1 and imem_req=0 for 20 cycles.
- RST pulsed low mid-MEM of sw → dmem_req and nWR drop async; after release, state=IF and imem_req=1. With CTRL_PERF_CNT_EN, all three counters read 0.
